// File: rtl/wb_wide_reg.sv
// Wishbone slave exposing one register of WORDS x 32 bits, address 0 = MSW.
// ATOMIC=1 gives shadow-buffered writes committed by the LSW and snapshot reads latched by the MSW.
module wb_wide_reg #(
  parameter int unsigned           WORDS     = 4,
  parameter int unsigned           ADR_W     = 2,
  parameter bit                    ATOMIC    = 1'b1,
  parameter logic [32*WORDS-1:0]   RESET_VAL = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic [ADR_W-1:0]      wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic [31:0]           wb_dat_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  output logic                  wb_stall_o,
  output logic [31:0]           wb_dat_o,
  output logic [32*WORDS-1:0]   reg_o,
  output logic                  commit_o,
  input  logic                  hw_load_i,
  input  logic [32*WORDS-1:0]   hw_data_i
);

  localparam int unsigned      W    = 32 * WORDS;
  localparam logic [ADR_W-1:0] LAST = ADR_W'(WORDS - 1);

  logic             rd_busy, rd_ack;
  logic             wr_busy, wr_pend, wr_ack;
  logic             commit_q;
  logic [ADR_W-1:0] wr_adr;
  logic [31:0]      wr_dat;
  logic [3:0]       wr_sel;
  logic [31:0]      dat_q;
  logic [W-1:0]     reg_q, shadow, snap;

  logic             rd_req, wr_req, wr_in_range, bus_reg_upd;
  logic [W-1:0]     wr_mask, wr_rep, shadow_base, shadow_merged, reg_direct;
  logic [31:0]      rd_live, rd_snap, rd_word;

  assign rd_req = wb_cyc_i & wb_stb_i & ~wb_we_i & ~rd_busy;
  assign wr_req = wb_cyc_i & wb_stb_i &  wb_we_i & ~wr_busy;

  // Out-of-range addresses match no word: zero mask, zero read data.
  always_comb begin
    wr_mask     = '0;
    wr_in_range = 1'b0;
    rd_live     = '0;
    rd_snap     = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (wr_adr == ADR_W'(i)) begin
        wr_in_range = 1'b1;
        wr_mask[32*(WORDS-1-i) +: 32] = {{8{wr_sel[3]}}, {8{wr_sel[2]}},
                                         {8{wr_sel[1]}}, {8{wr_sel[0]}}};
      end
      if (wb_adr_i == ADR_W'(i)) begin
        rd_live = reg_q[32*(WORDS-1-i) +: 32];
        rd_snap = snap[32*(WORDS-1-i) +: 32];
      end
    end
  end

  assign wr_rep        = {WORDS{wr_dat}};
  assign bus_reg_upd   = wr_pend & wr_in_range & (ATOMIC ? (wr_adr == LAST) : 1'b1);
  // A hw load that loses to a bus commit is dropped from the shadow as well.
  assign shadow_base   = (hw_load_i & ~bus_reg_upd) ? hw_data_i : shadow;
  assign shadow_merged = (shadow_base & ~wr_mask) | (wr_rep & wr_mask);
  assign reg_direct    = (reg_q & ~wr_mask) | (wr_rep & wr_mask);
  assign rd_word       = (ATOMIC && wb_adr_i != '0) ? rd_snap : rd_live;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_busy <= 1'b0;
      rd_ack  <= 1'b0;
      dat_q   <= '0;
      snap    <= '0;
    end else begin
      rd_ack <= rd_req;
      if (rd_req)      rd_busy <= 1'b1;
      else if (rd_ack) rd_busy <= 1'b0;
      if (rd_req) begin
        dat_q <= rd_word;
        if (ATOMIC && wb_adr_i == '0) snap <= reg_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_busy <= 1'b0;
      wr_pend <= 1'b0;
      wr_ack  <= 1'b0;
      wr_adr  <= '0;
      wr_dat  <= '0;
      wr_sel  <= '0;
    end else begin
      wr_pend <= wr_req;
      wr_ack  <= wr_pend;
      if (wr_req) begin
        wr_busy <= 1'b1;
        wr_adr  <= wb_adr_i;
        wr_dat  <= wb_dat_i;
        wr_sel  <= wb_sel_i;
      end else if (wr_ack) begin
        wr_busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      reg_q    <= RESET_VAL;
      shadow   <= RESET_VAL;
      commit_q <= 1'b0;
    end else begin
      commit_q <= bus_reg_upd;
      if (bus_reg_upd)    reg_q <= ATOMIC ? shadow_merged : reg_direct;
      else if (hw_load_i) reg_q <= hw_data_i;
      if (wr_pend && wr_in_range) shadow <= shadow_merged;
      else if (hw_load_i)         shadow <= hw_data_i;
    end
  end

  assign wb_ack_o   = rd_ack | wr_ack;
  assign wb_err_o   = 1'b0;
  assign wb_rty_o   = 1'b0;
  assign wb_stall_o = ~wb_ack_o & wb_cyc_i & wb_stb_i;
  assign wb_dat_o   = dat_q;
  assign reg_o      = reg_q;
  assign commit_o   = commit_q;

endmodule

// File: tb/tb_wb_wide_reg.sv
// Bench for wb_wide_reg: three instances (atomic 4-word, direct 4-word, atomic 3-word)
// share one bus and are compared every cycle against a word-array model of the register.
module tb_wb_wide_reg;

  logic         clk = 1'b0;
  logic         rst, cyc, stb, we, hw_load;
  logic [1:0]   adr;
  logic [3:0]   sel;
  logic [31:0]  wdat;
  logic [127:0] hw_data;

  logic         ack_v [3];
  logic         err_v [3];
  logic         rty_v [3];
  logic         stall_v [3];
  logic         com_v [3];
  logic [31:0]  dat_v [3];
  logic [127:0] reg_a, reg_b;
  logic [95:0]  reg_c;

  always #5 clk = ~clk;

  wb_wide_reg #(.WORDS(4), .ADR_W(2), .ATOMIC(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_adr_i(adr),
    .wb_sel_i(sel), .wb_we_i(we), .wb_dat_i(wdat), .wb_ack_o(ack_v[0]),
    .wb_err_o(err_v[0]), .wb_rty_o(rty_v[0]), .wb_stall_o(stall_v[0]),
    .wb_dat_o(dat_v[0]), .reg_o(reg_a), .commit_o(com_v[0]),
    .hw_load_i(hw_load), .hw_data_i(hw_data));

  wb_wide_reg #(.WORDS(4), .ADR_W(2), .ATOMIC(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_adr_i(adr),
    .wb_sel_i(sel), .wb_we_i(we), .wb_dat_i(wdat), .wb_ack_o(ack_v[1]),
    .wb_err_o(err_v[1]), .wb_rty_o(rty_v[1]), .wb_stall_o(stall_v[1]),
    .wb_dat_o(dat_v[1]), .reg_o(reg_b), .commit_o(com_v[1]),
    .hw_load_i(hw_load), .hw_data_i(hw_data));

  wb_wide_reg #(.WORDS(3), .ADR_W(2), .ATOMIC(1'b1)) dut_c (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_adr_i(adr),
    .wb_sel_i(sel), .wb_we_i(we), .wb_dat_i(wdat), .wb_ack_o(ack_v[2]),
    .wb_err_o(err_v[2]), .wb_rty_o(rty_v[2]), .wb_stall_o(stall_v[2]),
    .wb_dat_o(dat_v[2]), .reg_o(reg_c), .commit_o(com_v[2]),
    .hw_load_i(hw_load), .hw_data_i(hw_data[95:0]));

  // Model: per instance, word arrays indexed by bus address (0 = MSW).
  int unsigned wd [3] = '{4, 4, 3};
  bit          at [3] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] m_reg  [3][4];
  logic [31:0] m_sh   [3][4];
  logic [31:0] m_snap [3][4];
  bit          e_ack [3];
  bit          e_com [3];
  bit          e_rd;
  logic [31:0] e_dat [3];
  bit          checking = 1'b0;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [127:0] exp_vec(input int c);
    logic [127:0] v = '0;
    for (int a = 0; a < int'(wd[c]); a++) v[32*(int'(wd[c])-1-a) +: 32] = m_reg[c][a];
    return v;
  endfunction

  function automatic logic [127:0] dut_vec(input int c);
    if (c == 0) return reg_a;
    if (c == 1) return reg_b;
    return {32'h0, reg_c};
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 3; c++) begin
      for (int a = 0; a < 4; a++) begin
        m_reg[c][a] = '0; m_sh[c][a] = '0; m_snap[c][a] = '0;
      end
      e_ack[c] = 1'b0; e_com[c] = 1'b0; e_dat[c] = '0;
    end
    e_rd = 1'b0;
  endtask

  task automatic m_hw_one(input int c, input logic [127:0] hv);
    for (int a = 0; a < int'(wd[c]); a++) begin
      m_reg[c][a] = hv[32*(int'(wd[c])-1-a) +: 32];
      m_sh[c][a]  = m_reg[c][a];
    end
  endtask

  task automatic m_write(input int a, input logic [31:0] d, input logic [3:0] s,
                         input bit hw, input logic [127:0] hv);
    for (int c = 0; c < 3; c++) begin
      e_com[c] = 1'b0;
      if (a >= int'(wd[c])) begin
        if (hw) m_hw_one(c, hv);
      end else if (at[c]) begin
        if (a == int'(wd[c]) - 1) begin
          m_sh[c][a] = merge(m_sh[c][a], d, s);
          for (int k = 0; k < 4; k++) m_reg[c][k] = m_sh[c][k];
          e_com[c] = 1'b1;
        end else begin
          if (hw) m_hw_one(c, hv);
          m_sh[c][a] = merge(m_sh[c][a], d, s);
        end
      end else begin
        m_reg[c][a] = merge(m_reg[c][a], d, s);
        e_com[c] = 1'b1;
      end
    end
  endtask

  task automatic m_read(input int a);
    for (int c = 0; c < 3; c++) begin
      if (a >= int'(wd[c])) e_dat[c] = '0;
      else if (!at[c]) e_dat[c] = m_reg[c][a];
      else if (a == 0) begin
        e_dat[c] = m_reg[c][0];
        for (int k = 0; k < 4; k++) m_snap[c][k] = m_reg[c][k];
      end else e_dat[c] = m_snap[c][a];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ack(input bit v, input bit rd);
    for (int c = 0; c < 3; c++) e_ack[c] = v;
    e_rd = rd;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit hw, input logic [127:0] hv);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d; sel = s;
    step();
    if (hw) begin hw_load = 1'b1; hw_data = hv; end
    step();
    hw_load = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    m_write(int'(a), d, s, hw, hv);
    set_ack(1'b1, 1'b0);
    step();
    set_ack(1'b0, 1'b0);
    for (int c = 0; c < 3; c++) e_com[c] = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] qa, output logic [31:0] qc);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    step();
    m_read(int'(a));
    set_ack(1'b1, 1'b1);
    #2;
    qa = dat_v[0];
    qc = dat_v[2];
    step();
    cyc = 1'b0; stb = 1'b0;
    set_ack(1'b0, 1'b0);
  endtask

  task automatic hw_pulse(input logic [127:0] hv);
    hw_load = 1'b1; hw_data = hv;
    step();
    hw_load = 1'b0;
    for (int c = 0; c < 3; c++) m_hw_one(c, hv);
  endtask

  // Cycle-by-cycle comparison of all instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        for (int c = 0; c < 3; c++) begin
          chk($sformatf("ack[%0d]", c), {127'h0, ack_v[c]}, {127'h0, e_ack[c]});
          chk($sformatf("commit[%0d]", c), {127'h0, com_v[c]}, {127'h0, e_com[c]});
          chk($sformatf("reg_o[%0d]", c), dut_vec(c), exp_vec(c));
          chk($sformatf("stall[%0d]", c), {127'h0, stall_v[c]},
              {127'h0, ~e_ack[c] & cyc & stb});
          chk($sformatf("err_rty[%0d]", c), {126'h0, err_v[c], rty_v[c]}, 128'h0);
          if (e_rd) chk($sformatf("rd_data[%0d]", c), {96'h0, dat_v[c]}, {96'h0, e_dat[c]});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] qa, qc;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; hw_load = 1'b0;
    adr = '0; sel = '0; wdat = '0; hw_data = '0;
    m_reset();
    step(); step();
    rst = 1'b0;
    checking = 1'b1;
    chk("reset_dat", {96'h0, dat_v[0]}, 128'h0);
    chk("reset_reg", reg_a, 128'h0);

    bus_write(2'd0, 32'h11111111, 4'hF, 1'b0, '0);
    bus_write(2'd1, 32'h22222222, 4'hF, 1'b0, '0);
    bus_write(2'd2, 32'h33333333, 4'hF, 1'b0, '0);
    chk("atomic_hold", reg_a, 128'h0);
    bus_write(2'd3, 32'h44444444, 4'hF, 1'b0, '0);
    chk("atomic_commit", reg_a, 128'h11111111_22222222_33333333_44444444);

    bus_read(2'd0, qa, qc);
    chk("snap_rd0", {96'h0, qa}, {96'h0, 32'h11111111});
    hw_pulse({4{32'hFFFFFFFF}});
    bus_read(2'd1, qa, qc);
    chk("snap_rd1", {96'h0, qa}, {96'h0, 32'h22222222});
    bus_read(2'd2, qa, qc);
    chk("snap_rd2", {96'h0, qa}, {96'h0, 32'h33333333});
    bus_read(2'd3, qa, qc);
    chk("snap_rd3", {96'h0, qa}, {96'h0, 32'h44444444});
    bus_read(2'd0, qa, qc);
    chk("fresh_rd0", {96'h0, qa}, {96'h0, 32'hFFFFFFFF});

    bus_write(2'd3, 32'hAABBCCDD, 4'hF, 1'b0, '0);
    bus_write(2'd3, 32'h11223344, 4'b0101, 1'b0, '0);
    chk("byte_sel", {96'h0, reg_a[31:0]}, {96'h0, 32'hAA22CC44});

    bus_write(2'd3, 32'h55667788, 4'hF, 1'b1, 128'h01234567_89ABCDEF_0F1E2D3C_4B5A6978);
    chk("collision", reg_a, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_55667788);

    bus_write(2'd1, 32'h9ABCDEF0, 4'hF, 1'b0, '0);
    chk("direct_wr", {96'h0, reg_b[95:64]}, {96'h0, 32'h9ABCDEF0});

    bus_read(2'd3, qa, qc);
    chk("oor_read", {96'h0, qc}, 128'h0);

    // Reset lands while a write is pending: it must vanish without an ack.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 2'd3; wdat = 32'hDEADBEEF; sel = 4'hF;
    step();
    #1 rst = 1'b1;
    #1;
    chk("rst_async_reg", reg_a, 128'h0);
    chk("rst_async_ack", {127'h0, ack_v[0]}, 128'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    m_reset();
    step();
    rst = 1'b0;
    step(); step(); step();

    for (int n = 0; n < 250; n++) begin
      int unsigned kind = $urandom_range(0, 9);
      logic [1:0]   ra = 2'($urandom_range(0, 3));
      logic [31:0]  rd = $urandom;
      logic [3:0]   rs = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      bit           rh = ($urandom_range(0, 3) == 0);
      logic [127:0] rv = {$urandom, $urandom, $urandom, $urandom};
      if (kind < 5)      bus_write(ra, rd, rs, rh, rv);
      else if (kind < 9) bus_read(ra, qa, qc);
      else               hw_pulse(rv);
      if ($urandom_range(0, 3) == 0) step();
    end

    step();
    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
